irq_controller: RTL
===================

// Module: irq_controller
// PURPOSE
//  Receiving end of the core's NMI/IRQ[7:0] interrupt inputs: synchronises and latches events,
//  prioritises them, and presents one interrupt at a time to the pipeline with a req/ack handshake.
//  Tracks in-service state until int_ret (MRET retire). Sits between MainPath's NMI/IRQ pins and trap logic.
// PARAMETERS
//  NUM_IRQ   8             number of maskable lines (int_id width fixed at 4)
//  XLEN      32            vector address width
//  VEC_BASE  32'h0000_0080 handler base; int_vec = VEC_BASE + 4*int_id
// PORTS
//  clk         in   1        core clock, rising edge
//  rst         in   1        asynchronous, active-low reset
//  NMI         in   1        non-maskable request, async, rising-edge triggered
//  IRQ         in   NUM_IRQ  maskable requests, async
//  irq_mask    in   NUM_IRQ  per-line enable (1 = enabled)
//  glb_ie      in   1        global maskable enable from core status
//  int_ack     in   1        core accepts current request (trap taken)
//  int_ret     in   1        one-cycle pulse: MRET retired
//  int_req     out  1        interrupt request to core
//  int_id      out  4        0..7 = IRQ index, 8 = NMI
//  int_vec     out  XLEN     handler address
//  in_service  out  1        a handler is executing
//  irq_pending out  NUM_IRQ  latched pending bits
// BEHAVIOUR
//  - Reset: int_req=0, int_id=0, int_vec=VEC_BASE, in_service=0, irq_pending=0, syncs clear, state IDLE.
//    Asserting rst mid-operation clears everything immediately, including saved id.
//  - NMI/IRQ pass 2-flop synchroniser + edge register. Input first high at edge k -> pending set at edge k+2
//    -> int_req high after edge k+3 (from IDLE).
//  - Pending bit stays set until acked; repeated edges on a pending line coalesce.
//  - Priority: NMI > IRQ[0] > ... > IRQ[7]. Maskable eligible only if irq_mask[i] & glb_ie.
//  - FSM: IDLE, REQ, SERV, NMI_REQ, SERV_NMI.
//    IDLE: eligible pending -> REQ (NMI wins). int_ret ignored.
//    REQ: int_req=1; int_id/int_vec frozen. int_req&int_ack -> clear that pending bit, SERV (SERV_NMI if id 8).
//      Maskable req withdrawn (-> IDLE next cycle) if its mask bit or glb_ie drops before ack. NMI never withdrawn.
//      NMI edge while REQ holds a maskable id: request switches to NMI next cycle (id 8), maskable stays pending.
//    SERV: in_service=1, int_req=0; new IRQs only pend. NMI pending -> NMI_REQ (save current id).
//      int_ret -> IDLE.
//    NMI_REQ: int_req=1, id 8; ack -> SERV_NMI.
//    SERV_NMI: int_ret -> SERV with saved IRQ id if NMI preempted an IRQ, else IDLE. NMI edges coalesce.
//  - int_ack while int_req=0 ignored. Same-edge new event and ack-clear on one bit: set wins (re-pends).
//  - int_vec = VEC_BASE + {int_id,2'b00}, zero-extended, wraps modulo 2^XLEN.
// CONFIGURATION
//  IRQ_LEVEL_TRIG_EN defined: IRQ lines level-sensitive; irq_pending = synced IRQ (no latch, ack clears
//    nothing; source must deassert before int_ret or it re-requests). NMI stays edge-triggered.
//  Undefined (default): IRQ lines rising-edge latched as above.
// TESTING
//  1 rst=0 3 cycles, IRQ=8'hFF, NMI=1 -> all outputs at reset values; release, no spurious int_req from held levels
//    in edge mode.
//  2 mask=FF, glb_ie=1, pulse IRQ[2] -> int_req after edge k+3, int_id=2, int_vec=0x88; ack -> irq_pending[2]=0,
//    in_service=1; int_ret -> IDLE.
//  3 IRQ=8'h81 same cycle -> id 0 (0x80) first; ack+int_ret -> id 7 (0x9C) requested.
//  4 serving IRQ3, NMI rises -> int_req id 8, vec 0xA0; ack; int_ret -> in_service=1, int_id=3; int_ret -> IDLE.
//  5 mask=8'hFE, pulse IRQ0 -> irq_pending[0]=1, no req; set mask[0] -> req; drop glb_ie in REQ -> req withdrawn
//    next cycle.
//  6 IRQ5 edge on ack edge of IRQ5 -> pending[5] re-set; rst low during SERV_NMI -> immediate reset values.

Source files
------------

// File: rtl/irq_controller.sv
// irq_controller: synchronises NMI/IRQ inputs, prioritises them and presents one interrupt at a time to the core.
// Optional macro IRQ_LEVEL_TRIG_EN makes IRQ lines level-sensitive (NMI always stays edge-triggered).
//
// state    | meaning
// IDLE     | nothing presented, nothing in service
// REQ      | presenting int_id (maskable or NMI) and waiting for int_ack
// SERV     | maskable handler executing
// NMI_REQ  | NMI presented while a maskable handler is executing
// SERV_NMI | NMI handler executing
module irq_controller #(
    parameter int              NUM_IRQ  = 8,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] VEC_BASE = XLEN'(32'h0000_0080)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               NMI,
    input  logic [NUM_IRQ-1:0] IRQ,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               glb_ie,
    input  logic               int_ack,
    input  logic               int_ret,
    output logic               int_req,
    output logic [3:0]         int_id,
    output logic [XLEN-1:0]    int_vec,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] irq_pending
);

    localparam logic [3:0] NMI_ID = 4'd8;

    typedef enum logic [2:0] {IDLE, REQ, SERV, NMI_REQ, SERV_NMI} state_t;

    state_t             state, state_nx;
    logic [3:0]         cur_id, cur_id_nx;
    logic [3:0]         saved_id, saved_id_nx;
    logic               saved_vld, saved_vld_nx;

    logic [NUM_IRQ-1:0] irq_s1, irq_s2, irq_q;
    logic               nmi_s1, nmi_s2, nmi_q;
    logic [1:0]         warm;
    logic               nmi_rise;
    logic               nmi_pend;

    logic [NUM_IRQ-1:0] clr_irq;
    logic               clr_nmi;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] cur_hot;
    logic               pick_vld;
    logic [3:0]         pick_id;
    logic               cur_elig;

    // The edge register reads as "high" until the synchronisers have filled, so a
    // level held through reset is not mistaken for a fresh rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_s1 <= '0;
            irq_s2 <= '0;
            irq_q  <= '1;
            nmi_s1 <= 1'b0;
            nmi_s2 <= 1'b0;
            nmi_q  <= 1'b1;
            warm   <= 2'b00;
        end else begin
            irq_s1 <= IRQ;
            irq_s2 <= irq_s1;
            nmi_s1 <= NMI;
            nmi_s2 <= nmi_s1;
            warm   <= {warm[0], 1'b1};
            irq_q  <= warm[1] ? irq_s2 : '1;
            nmi_q  <= warm[1] ? nmi_s2 : 1'b1;
        end
    end

    assign nmi_rise = nmi_s2 & ~nmi_q;

`ifdef IRQ_LEVEL_TRIG_EN
    assign irq_pending = irq_s2;
`else
    logic [NUM_IRQ-1:0] irq_rise;
    logic [NUM_IRQ-1:0] pend_q;

    assign irq_rise = irq_s2 & ~irq_q;

    // A new edge on the same clock as the ack-clear re-pends the line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~clr_irq) | irq_rise;
        end
    end

    assign irq_pending = pend_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nmi_pend <= 1'b0;
        end else begin
            nmi_pend <= (nmi_pend & ~clr_nmi) | nmi_rise;
        end
    end

    always_comb begin
        eligible = irq_pending & irq_mask & {NUM_IRQ{glb_ie}};
        pick_vld = 1'b0;
        pick_id  = 4'd0;
        cur_elig = 1'b0;
        cur_hot  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                pick_vld = 1'b1;
                pick_id  = 4'(i);
            end
            if (cur_id == 4'(i)) begin
                cur_elig   = eligible[i];
                cur_hot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cur_id    <= 4'd0;
            saved_id  <= 4'd0;
            saved_vld <= 1'b0;
        end else begin
            state     <= state_nx;
            cur_id    <= cur_id_nx;
            saved_id  <= saved_id_nx;
            saved_vld <= saved_vld_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cur_id_nx    = cur_id;
        saved_id_nx  = saved_id;
        saved_vld_nx = saved_vld;
        clr_irq      = '0;
        clr_nmi      = 1'b0;
        case (state)
            IDLE: begin
                if (nmi_pend) begin
                    state_nx  = REQ;
                    cur_id_nx = NMI_ID;
                end else if (pick_vld) begin
                    state_nx  = REQ;
                    cur_id_nx = pick_id;
                end
            end
            REQ: begin
                if (int_ack) begin
                    if (cur_id == NMI_ID) begin
                        clr_nmi  = 1'b1;
                        state_nx = SERV_NMI;
                    end else begin
                        clr_irq  = cur_hot;
                        state_nx = SERV;
                    end
                end else if (cur_id != NMI_ID && nmi_pend) begin
                    cur_id_nx = NMI_ID;
                end else if (cur_id != NMI_ID && !cur_elig) begin
                    state_nx = IDLE;
                end
            end
            SERV: begin
                if (nmi_pend) begin
                    state_nx     = NMI_REQ;
                    saved_id_nx  = cur_id;
                    saved_vld_nx = 1'b1;
                    cur_id_nx    = NMI_ID;
                end else if (int_ret) begin
                    state_nx = IDLE;
                end
            end
            NMI_REQ: begin
                if (int_ack) begin
                    clr_nmi  = 1'b1;
                    state_nx = SERV_NMI;
                end
            end
            SERV_NMI: begin
                if (int_ret) begin
                    if (saved_vld) begin
                        state_nx     = SERV;
                        cur_id_nx    = saved_id;
                        saved_vld_nx = 1'b0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign int_req    = (state == REQ) || (state == NMI_REQ);
    assign in_service = (state == SERV) || (state == NMI_REQ) || (state == SERV_NMI);
    assign int_id     = cur_id;
    assign int_vec    = VEC_BASE + XLEN'({cur_id, 2'b00});

endmodule
